// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds FSM state encoding, port ids, write-enable lane codes, latch bundle.
package dmem_arbiter_pkg;

    localparam int AW = 8;
    localparam int DW = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_EXT = 1'b1
    } port_e;

    // Active-low per-lane write enables.
    localparam logic [3:0] WREN_NONE = 4'b1111;
    localparam logic [3:0] WREN_WORD = 4'b0000;
    localparam logic [3:0] WREN_HALF = 4'b1100;
    localparam logic [3:0] WREN_BYTE = 4'b1110;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wren;
    } acc_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester port bundle: req/addr/wdata/wren in, ack/rdata back.
// master = requester side, slave = arbiter side.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wren;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (
        output req, addr, wdata, wren,
        input  ack, rdata
    );

    modport slave (
        input  req, addr, wdata, wren,
        output ack, rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant; bit 0 = CPU, bit 1 = EXT.
// Ports: clk_i, rstd_i, req_i[1:0], en_i (commit grant), valid_o, gnt_o.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstd_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       valid_o,
    output port_e      gnt_o
);

    port_e last_q;

    always_comb begin
        valid_o = |req_i;
        gnt_o   = PORT_CPU;
        if (req_i[0] && req_i[1]) begin
            // On a tie the port not served last wins.
            if (last_q == PORT_CPU) begin
                gnt_o = PORT_EXT;
            end
        end else if (req_i[1]) begin
            gnt_o = PORT_EXT;
        end
    end

    // Reset to EXT so the CPU wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rstd_i) begin
            last_q <= PORT_EXT;
        end else if (en_i && valid_o) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and EXT requesters onto one byte-lane data memory.
// Ports: clk, rstd, cpu/ext (slave bundles), mem_* bus, busy.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rstd,
    dmem_arbiter_if.slave cpu,
    dmem_arbiter_if.slave ext,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_wren,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    state_e        state_q;
    port_e         gnt_q;
    acc_t          acc_q;
    acc_t          acc_d;
    logic          cpu_ack_q;
    logic          ext_ack_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ext_rdata_q;
    logic          busy_q;

    logic          arb_valid;
    port_e         arb_gnt;
    logic          arb_en;

    assign arb_en = (state_q == S_IDLE);

    rr_arb2 u_arb (
        .clk_i   (clk),
        .rstd_i  (rstd),
        .req_i   ({ext.req, cpu.req}),
        .en_i    (arb_en),
        .valid_o (arb_valid),
        .gnt_o   (arb_gnt)
    );

    always_comb begin
        acc_d.addr  = cpu.addr;
        acc_d.wdata = cpu.wdata;
        acc_d.wren  = cpu.wren;
        if (arb_gnt == PORT_EXT) begin
            acc_d.addr  = ext.addr;
            acc_d.wdata = ext.wdata;
            acc_d.wren  = ext.wren;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstd) begin
            state_q     <= S_IDLE;
            gnt_q       <= PORT_CPU;
            acc_q.addr  <= '0;
            acc_q.wdata <= '0;
            acc_q.wren  <= WREN_NONE;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            ext_ack_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (arb_valid) begin
                        state_q <= S_ACC;
                        busy_q  <= 1'b1;
                        gnt_q   <= arb_gnt;
                        acc_q   <= acc_d;
                    end
                end
                S_ACC: begin
                    // Capture read data and raise ack for RESP.
                    state_q <= S_RESP;
                    if (gnt_q == PORT_EXT) begin
                        ext_rdata_q <= mem_rdata;
                        ext_ack_q   <= 1'b1;
                    end else begin
                        cpu_rdata_q <= mem_rdata;
                        cpu_ack_q   <= 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates the write enable so an aborted ACC writes nothing.
    assign mem_wren = (rstd && state_q == S_ACC)
                    ? acc_q.wren : WREN_NONE;
    assign mem_addr  = acc_q.addr;
    assign mem_wdata = acc_q.wdata;
    assign busy      = busy_q;

    assign cpu.ack   = cpu_ack_q;
    assign cpu.rdata = cpu_rdata_q;
    assign ext.ack   = ext_ack_q;
    assign ext.rdata = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-lane memory model.
// Checks reset, latency, lane writes, round-robin and reset abort.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rstd = 1'b0;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wren;
    logic [31:0] mem_rdata;
    logic        busy;

    dmem_arbiter_if cpu_if ();
    dmem_arbiter_if ext_if ();

    dmem_arbiter dut (
        .clk       (clk),
        .rstd      (rstd),
        .cpu       (cpu_if),
        .ext       (ext_if),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (!mem_wren[n]) begin
                mem[mem_addr][8*n +: 8] <= mem_wdata[8*n +: 8];
            end
        end
    end

    int cyc = 0;
    int wr_cyc = 0;
    int both_cnt = 0;
    int log_port[$];
    int log_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cpu_if.ack && ext_if.ack) both_cnt++;
        if (cpu_if.ack) begin
            log_port.push_back(0);
            log_cyc.push_back(cyc);
        end
        if (ext_if.ack) begin
            log_port.push_back(1);
            log_cyc.push_back(cyc);
        end
        if (mem_wren != 4'hF) wr_cyc++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic cpu_xfer(input logic [7:0] a,
                            input logic [31:0] d,
                            input logic [3:0] we,
                            output logic [31:0] rd,
                            output int lat);
        cpu_if.req   = 1'b1;
        cpu_if.addr  = a;
        cpu_if.wdata = d;
        cpu_if.wren  = we;
        lat = -1;
        rd  = 'x;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (cpu_if.ack) begin
                rd  = cpu_if.rdata;
                lat = i;
                break;
            end
        end
        cpu_if.req  = 1'b0;
        cpu_if.wren = WREN_NONE;
        if (lat < 0) check("cpu_timeout", 32'd0, 32'd1);
    endtask

    task automatic ext_xfer(input logic [7:0] a,
                            input logic [31:0] d,
                            input logic [3:0] we,
                            output logic [31:0] rd,
                            output int lat);
        ext_if.req   = 1'b1;
        ext_if.addr  = a;
        ext_if.wdata = d;
        ext_if.wren  = we;
        lat = -1;
        rd  = 'x;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ext_if.ack) begin
                rd  = ext_if.rdata;
                lat = i;
                break;
            end
        end
        ext_if.req  = 1'b0;
        ext_if.wren = WREN_NONE;
        if (lat < 0) check("ext_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_pulse();
        rstd = 1'b0;
        @(negedge clk);
        rstd = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] rd_c;
        logic [31:0] rd_e;
        int          lat;
        int          lat_c;
        int          lat_e;

        cpu_if.req   = 1'b0;
        cpu_if.addr  = '0;
        cpu_if.wdata = '0;
        cpu_if.wren  = WREN_NONE;
        ext_if.req   = 1'b0;
        ext_if.addr  = '0;
        ext_if.wdata = '0;
        ext_if.wren  = WREN_NONE;

        rstd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cpu_ack", 32'(cpu_if.ack), 32'd0);
        check("rst_ext_ack", 32'(ext_if.ack), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'hF);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_cpu_rd", cpu_if.rdata, 32'd0);
        check("rst_ext_rd", ext_if.rdata, 32'd0);
        rstd = 1'b1;
        @(negedge clk);

        // CPU word write then readback.
        wr_cyc = 0;
        cpu_xfer(8'h10, 32'hDEADBEEF, WREN_WORD, rd, lat);
        check("wr_lat", 32'(lat), 32'd2);
        @(negedge clk);
        check("wr_cycles", 32'(wr_cyc), 32'd1);
        check("idle_addr_hold", 32'(mem_addr), 32'h10);
        check("idle_wren", 32'(mem_wren), 32'hF);
        check("idle_busy", 32'(busy), 32'd0);
        cpu_xfer(8'h10, 32'h0, WREN_NONE, rd, lat);
        check("rd_10", rd, 32'hDEADBEEF);
        check("rd_lat", 32'(lat), 32'd2);

        // Lane writes from EXT.
        ext_xfer(8'h20, 32'h5555AAAA, WREN_WORD, rd, lat);
        cpu_xfer(8'h30, 32'h11223344, WREN_WORD, rd, lat);
        cpu_xfer(8'h31, 32'h11223344, WREN_WORD, rd, lat);
        cpu_xfer(8'h20, 32'h0, WREN_NONE, rd, lat);
        check("cpu_rd_20", rd, 32'h5555AAAA);
        ext_xfer(8'h30, 32'h000000AA, WREN_BYTE, rd, lat);
        check("ext_rbw", rd, 32'h11223344);
        ext_xfer(8'h31, 32'hFFFFBEEF, WREN_HALF, rd, lat);
        check("cpu_rd_hold", cpu_if.rdata, 32'h5555AAAA);
        cpu_xfer(8'h30, 32'h0, WREN_NONE, rd, lat);
        check("byte_wr", rd, 32'h112233AA);
        cpu_xfer(8'h31, 32'h0, WREN_NONE, rd, lat);
        check("half_wr", rd, 32'h1122BEEF);

        // Simultaneous first requests after reset.
        reset_pulse();
        log_port.delete();
        log_cyc.delete();
        fork
            begin
                cpu_xfer(8'h10, 32'h0, WREN_NONE, rd_c, lat_c);
                check("tie_cpu_rd", rd_c, 32'hDEADBEEF);
                check("tie_cpu_lat", 32'(lat_c), 32'd2);
                check("tie_ext_hold", ext_if.rdata, 32'd0);
            end
            begin
                ext_xfer(8'h20, 32'h0, WREN_NONE, rd_e, lat_e);
                check("tie_ext_rd", rd_e, 32'h5555AAAA);
                check("tie_ext_lat", 32'(lat_e), 32'd5);
            end
        join
        @(negedge clk);
        #1;
        check("tie_n_acks", 32'(log_port.size()), 32'd2);
        if (log_port.size() == 2) begin
            check("tie_first", 32'(log_port[0]), 32'd0);
            check("tie_second", 32'(log_port[1]), 32'd1);
            check("tie_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd3);
        end

        // Continuous requests from both ports.
        reset_pulse();
        log_port.delete();
        log_cyc.delete();
        cpu_if.req   = 1'b1;
        cpu_if.addr  = 8'h10;
        cpu_if.wren  = WREN_NONE;
        ext_if.req   = 1'b1;
        ext_if.addr  = 8'h20;
        ext_if.wren  = WREN_NONE;
        repeat (12) @(negedge clk);
        cpu_if.req = 1'b0;
        ext_if.req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rr_n_acks", 32'(log_port.size()), 32'd4);
        if (log_port.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rr_port%0d", i),
                      32'(log_port[i]), 32'(i % 2));
            end
        end
        check("rr_cpu_rd", cpu_if.rdata, 32'hDEADBEEF);
        check("rr_ext_rd", ext_if.rdata, 32'h5555AAAA);

        // Reset during the ACC cycle of a write.
        cpu_xfer(8'h40, 32'h0BADF00D, WREN_WORD, rd, lat);
        @(negedge clk);
        log_port.delete();
        log_cyc.delete();
        cpu_if.req   = 1'b1;
        cpu_if.addr  = 8'h40;
        cpu_if.wdata = 32'h12345678;
        cpu_if.wren  = WREN_WORD;
        @(negedge clk);
        check("abort_acc_wren", 32'(mem_wren), 32'h0);
        check("abort_acc_busy", 32'(busy), 32'd1);
        rstd = 1'b0;
        cpu_if.req  = 1'b0;
        cpu_if.wren = WREN_NONE;
        #1;
        check("abort_wren_gated", 32'(mem_wren), 32'hF);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(cpu_if.ack), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_wdata", mem_wdata, 32'd0);
        check("abort_mem", mem[8'h40], 32'h0BADF00D);
        rstd = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("abort_no_ack", 32'(log_port.size()), 32'd0);
        @(negedge clk);
        cpu_xfer(8'h40, 32'h0, WREN_NONE, rd, lat);
        check("abort_readback", rd, 32'h0BADF00D);

        @(negedge clk);
        #1;
        check("never_both_ack", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
